// File: rtl/cpu_dump_pkg.sv
// Shared constants and state type for the CPU state dumper.
// The frame holds a 4-word header, then the GPRs, then the data-memory words.
package cpu_dump_pkg;

  localparam int unsigned OFS_HDR   = 0;
  localparam int unsigned OFS_REG   = 4;
  localparam int unsigned OFS_MEM   = 36;
  localparam int unsigned FRAME_LEN = 44;

  typedef enum logic {
    IDLE,
    SEND
  } dump_state_t;

endpackage

// File: rtl/event_counter.sv
// Free-running event counter that wraps modulo 2^DATA_W when enabled.
module event_counter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [DATA_W-1:0] count_o
);

  logic [DATA_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = count_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_state_dumper.sv
// Snapshots CPU counters and PC on a trigger, then streams them plus all GPRs and
// the first data-memory words as one valid/ready frame while holding the CPU frozen.
module cpu_state_dumper
  import cpu_dump_pkg::*;
#(
  parameter int unsigned NUM_REGS      = OFS_MEM - OFS_REG,
  parameter int unsigned NUM_MEM_WORDS = FRAME_LEN - OFS_MEM,
  parameter int unsigned DATA_W        = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              trigger_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [4:0]        reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic              freeze_o,
  output logic              overrun_o
);

  localparam int unsigned OfsMem   = OFS_REG + NUM_REGS;
  localparam int unsigned FrameLen = OfsMem + NUM_MEM_WORDS;
  localparam int unsigned IdxW     = $clog2(FrameLen + 1);

  localparam logic [IdxW-1:0] IdxCyc   = IdxW'(OFS_HDR);
  localparam logic [IdxW-1:0] IdxStall = IdxW'(OFS_HDR + 1);
  localparam logic [IdxW-1:0] IdxFlush = IdxW'(OFS_HDR + 2);
  localparam logic [IdxW-1:0] IdxReg   = IdxW'(OFS_REG);
  localparam logic [IdxW-1:0] IdxMem   = IdxW'(OfsMem);
  localparam logic [IdxW-1:0] IdxEnd   = IdxW'(FrameLen);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(FrameLen - 1);

  dump_state_t       state_d, state_q;
  logic [IdxW-1:0]   idx_d, idx_q;
  logic [DATA_W-1:0] snap_cycle_d, snap_cycle_q;
  logic [DATA_W-1:0] snap_stall_d, snap_stall_q;
  logic [DATA_W-1:0] snap_flush_d, snap_flush_q;
  logic [DATA_W-1:0] snap_pc_d, snap_pc_q;
  logic              valid_d, valid_q;
  logic              last_d, last_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic              overrun_d, overrun_q;

  logic              busy;
  logic              cnt_en;
  logic [DATA_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] mem_off;
  logic              in_reg, in_mem;

  assign busy   = (state_q == SEND);
  // Counting stops while the CPU is frozen so the next frame stays consistent.
  assign cnt_en = start_i & ~busy;

  event_counter #(.DATA_W(DATA_W)) u_cycle_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (cnt_en),
    .count_o(cycle_cnt)
  );

  event_counter #(.DATA_W(DATA_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (cnt_en & stall_i),
    .count_o(stall_cnt)
  );

  event_counter #(.DATA_W(DATA_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .en_i   (cnt_en & flush_i),
    .count_o(flush_cnt)
  );

  // Debug read addresses track the word about to be loaded; zero outside their windows.
  assign in_reg     = busy && (idx_q >= IdxReg) && (idx_q < IdxMem);
  assign in_mem     = busy && (idx_q >= IdxMem) && (idx_q < IdxEnd);
  assign mem_off    = DATA_W'(idx_q - IdxMem);
  assign reg_addr_o = in_reg ? 5'(idx_q - IdxReg) : '0;
  assign mem_addr_o = in_mem ? (mem_off << 2) : '0;

  always_comb begin
    word = mem_data_i;
    if (idx_q < IdxReg) begin
      case (idx_q)
        IdxCyc:   word = snap_cycle_q;
        IdxStall: word = snap_stall_q;
        IdxFlush: word = snap_flush_q;
        default:  word = snap_pc_q;
      endcase
    end else if (idx_q < IdxMem) begin
      word = reg_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_cycle_d = snap_cycle_q;
    snap_stall_d = snap_stall_q;
    snap_flush_d = snap_flush_q;
    snap_pc_d    = snap_pc_q;
    valid_d      = valid_q;
    last_d       = last_q;
    data_d       = data_q;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (trigger_i) begin
          state_d      = SEND;
          idx_d        = '0;
          snap_cycle_d = cycle_cnt;
          snap_stall_d = stall_cnt;
          snap_flush_d = flush_cnt;
          snap_pc_d    = pc_i;
        end
      end
      SEND: begin
        if (trigger_i) begin
          overrun_d = 1'b1;
        end
        if (valid_q && dump_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = IDLE;
          end
        end
        if ((!valid_q || dump_ready_i) && (idx_q < IdxEnd)) begin
          valid_d = 1'b1;
          data_d  = word;
          last_d  = (idx_q == IdxLast);
          idx_d   = idx_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_cycle_q <= '0;
      snap_stall_q <= '0;
      snap_flush_q <= '0;
      snap_pc_q    <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      data_q       <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_cycle_q <= snap_cycle_d;
      snap_stall_q <= snap_stall_d;
      snap_flush_q <= snap_flush_d;
      snap_pc_q    <= snap_pc_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      data_q       <= data_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = last_q;
  assign busy_o       = busy;
  assign freeze_o     = busy;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Randomized bench for cpu_state_dumper against a frame-level reference model;
// a second 8-bit instance exercises counter wrap in a short run.
module tb_cpu_state_dumper;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned NM = 8;
  localparam int unsigned FL = 4 + NR + NM;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stall = 1'b0, flush = 1'b0, trig = 1'b0, ready = 1'b1;
  logic [DW-1:0] pc = '0;
  logic [4:0]    reg_addr;
  logic [DW-1:0] reg_data, mem_addr, mem_data, data;
  logic          valid, last, busy, freeze, overrun;

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] mem  [NM];

  assign reg_data = regs[reg_addr];
  assign mem_data = (mem_addr < DW'(4 * NM)) ? mem[mem_addr[4:2]] : 32'hDEAD_BEEF;

  // Narrow instance used only for the wrap test.
  logic       s_start = 1'b0, s_trig = 1'b0, s_ready = 1'b1;
  logic [7:0] s_pc = 8'h77;
  logic [4:0] s_reg_addr;
  logic [7:0] s_reg_data, s_mem_addr, s_mem_data, s_data;
  logic       s_valid, s_last, s_busy, s_freeze, s_overrun;

  assign s_reg_data = {3'b000, s_reg_addr};
  assign s_mem_data = s_mem_addr ^ 8'h3C;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  cpu_state_dumper dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .stall_i     (stall),
    .flush_i     (flush),
    .trigger_i   (trig),
    .pc_i        (pc),
    .reg_addr_o  (reg_addr),
    .reg_data_i  (reg_data),
    .mem_addr_o  (mem_addr),
    .mem_data_i  (mem_data),
    .dump_valid_o(valid),
    .dump_ready_i(ready),
    .dump_data_o (data),
    .dump_last_o (last),
    .busy_o      (busy),
    .freeze_o    (freeze),
    .overrun_o   (overrun)
  );

  cpu_state_dumper #(.DATA_W(8)) dut_small (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (s_start),
    .stall_i     (1'b0),
    .flush_i     (1'b0),
    .trigger_i   (s_trig),
    .pc_i        (s_pc),
    .reg_addr_o  (s_reg_addr),
    .reg_data_i  (s_reg_data),
    .mem_addr_o  (s_mem_addr),
    .mem_data_i  (s_mem_data),
    .dump_valid_o(s_valid),
    .dump_ready_i(s_ready),
    .dump_data_o (s_data),
    .dump_last_o (s_last),
    .busy_o      (s_busy),
    .freeze_o    (s_freeze),
    .overrun_o   (s_overrun)
  );

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: counters, frame contents and handshake bookkeeping, sampled at negedge.
  logic [DW-1:0] m_cyc, m_stall, m_flush;
  bit            m_frame, m_overrun;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_w [FL];
  int unsigned   n_acc = 0, frames = 0, busy_neg = 0;
  bit            hold_pend;
  logic [DW-1:0] hold_data;
  logic          hold_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cyc = '0; m_stall = '0; m_flush = '0;
      m_frame = 0; m_overrun = 0; n_acc = 0; hold_pend = 0;
      exp_q.delete();
    end else begin
      check_eq("busy", busy, m_frame);
      check_eq("freeze", freeze, m_frame);
      check_eq("overrun", overrun, m_overrun);
      if (busy) busy_neg++;
      if (hold_pend) begin
        check_eq("hold_valid", valid, 1);
        check_eq("hold_data", data, hold_data);
        check_eq("hold_last", last, hold_last);
      end
      hold_pend = valid && !ready;
      hold_data = data;
      hold_last = last;
      if (!m_frame) begin
        if (trig) begin
          exp_q = {m_cyc, m_stall, m_flush, pc};
          for (int i = 0; i < NR; i++) exp_q.push_back(regs[i]);
          for (int i = 0; i < NM; i++) exp_q.push_back(mem[i]);
          m_frame = 1;
          n_acc   = 0;
        end
        if (start) begin
          m_cyc++;
          if (stall) m_stall++;
          if (flush) m_flush++;
        end
      end else begin
        if (trig) m_overrun = 1;
        if (valid && ready) begin
          check_eq($sformatf("word%0d", n_acc), data, exp_q[n_acc]);
          check_eq($sformatf("last%0d", n_acc), last, n_acc == FL - 1);
          got_w[n_acc] = data;
          n_acc++;
          if (n_acc == FL) begin
            m_frame = 0;
            frames++;
          end
        end
      end
    end
  end

  logic [7:0]  s_w0;
  int unsigned s_cnt = 0, s_frames = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_cnt = 0;
    end else if (s_valid && s_ready) begin
      if (s_cnt == 0) s_w0 = s_data;
      if (s_last) begin
        s_cnt = 0;
        s_frames++;
      end else begin
        s_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pc = $urandom();
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step(1);
    trig = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggles every clock, 2: random
  task automatic run_frame(input int mode, input int budget);
    int unsigned f0 = frames;
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      step(1);
      done = (frames != f0);
    end
    ready = 1'b1;
    check_eq("frame_done", done, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, valid, 0);
    check_eq({tag, "_last"}, last, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_freeze"}, freeze, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
    check_eq({tag, "_data"}, data, 0);
    check_eq({tag, "_reg_addr"}, reg_addr, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
  endtask

  task automatic wait_small(input int budget);
    int unsigned f0 = s_frames;
    for (int i = 0; i < budget && s_frames == f0; i++) step(1);
    check_eq("small_frame_done", s_frames != f0, 1);
  endtask

  initial begin
    logic [DW-1:0] pc_trig;
    int unsigned   b0;

    for (int i = 0; i < NR; i++) regs[i] = $urandom();
    for (int i = 0; i < NM; i++) mem[i] = $urandom();
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // 1: ten counting clocks, then one frame with ready held high
    start = 1'b1;
    step(10);
    start   = 1'b0;
    b0      = busy_neg;
    pc_trig = pc;
    pulse_trig();
    run_frame(0, 200);
    step(1);
    check_eq("s1_busy_clocks", busy_neg - b0, 45);
    check_eq("s1_w0", got_w[0], 10);
    check_eq("s1_w3_pc", got_w[3], pc_trig);

    // 2: known register/memory contents; start stays high through the frame
    for (int i = 0; i < NR; i++) regs[i] = DW'(i + 100);
    mem[0] = 32'd5;
    for (int i = 1; i < NM; i++) mem[i] = $urandom();
    start = 1'b1;
    step(5);
    stall = 1'b1;
    flush = 1'b1;
    pulse_trig();
    run_frame(0, 200);
    check_eq("s2_w4", got_w[4], 100);
    check_eq("s2_w35", got_w[35], 131);
    check_eq("s2_w36", got_w[36], 5);
    check_eq("s2_w43", got_w[43], mem[7]);
    start = 1'b0; stall = 1'b0; flush = 1'b0;

    // 3: back-pressure, toggling then random
    for (int i = 0; i < NR; i++) regs[i] = $urandom();
    for (int i = 0; i < NM; i++) mem[i] = $urandom();
    pulse_trig();
    run_frame(1, 300);
    start = 1'b1;
    step($urandom_range(1, 7));
    start = 1'b0;
    pulse_trig();
    run_frame(2, 400);

    // 4: stall/flush counting from a fresh reset, counters frozen during the frame
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    start = 1'b1;
    stall = 1'b1;
    step(3);
    stall = 1'b0;
    flush = 1'b1;
    step(2);
    flush = 1'b0;
    start = 1'b0;
    pulse_trig();
    start = 1'b1; stall = 1'b1; flush = 1'b1;
    run_frame(2, 400);
    start = 1'b0; stall = 1'b0; flush = 1'b0;
    check_eq("s4_w0", got_w[0], 5);
    check_eq("s4_w1", got_w[1], 3);
    check_eq("s4_w2", got_w[2], 2);

    // 5: trigger while busy sets overrun; reset mid-frame abandons it
    start = 1'b1;
    step(4);
    start = 1'b0;
    pulse_trig();
    for (int i = 0; i < 200 && n_acc < 20; i++) step(1);
    check_eq("s5_reach20", n_acc >= 20, 1);
    pulse_trig();
    check_eq("s5_overrun", overrun, 1);
    for (int i = 0; i < 200 && n_acc < 30; i++) step(1);
    check_eq("s5_reach30", n_acc >= 30, 1);
    check_eq("s5_still_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("s5_midreset");
    step(2);
    rst_n = 1'b1;
    step(2);
    check_all_zero("s5_after");

    // 6: 8-bit counter reaches 2^8-1, then wraps to 0 after one more clock
    s_start = 1'b1;
    step(255);
    s_start = 1'b0;
    s_trig  = 1'b1;
    step(1);
    s_trig = 1'b0;
    wait_small(200);
    check_eq("s6_w0_max", s_w0, 8'hFF);
    s_start = 1'b1;
    step(1);
    s_start = 1'b0;
    s_trig  = 1'b1;
    step(1);
    s_trig = 1'b0;
    wait_small(200);
    check_eq("s6_w0_wrap", s_w0, 8'h00);
    check_eq("s6_overrun", s_overrun, 0);
    check_eq("s6_freeze", s_freeze, s_busy);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
